// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: a run/stop/done sequencer bounded by a cycle budget,
// driving per-channel divide-by-D enable pulses and toggling half-rate strobes.
module clk_en_gen #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RUN_CYCLES = 10000
) (
    input  logic                    clk25,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    cfg_load,
    output logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       ch_clk,
    output logic                    running,
    output logic                    done,
    output logic [CNT_W-1:0]        cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam bit               BOUNDED    = (RUN_CYCLES != 0);
    localparam logic [CNT_W-1:0] LAST_CYCLE = BOUNDED ? CNT_W'(RUN_CYCLES - 1) : '0;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cycle_cnt_q, cycle_cnt_d;
    logic                    running_q, running_d;
    logic                    done_q, done_d;
    logic [NUM_CH-1:0]       ch_en_q, ch_en_d;
    logic [NUM_CH-1:0]       ch_clk_q, ch_clk_d;
    logic [DIV_W-1:0]        act_q  [NUM_CH];
    logic [DIV_W-1:0]        act_d  [NUM_CH];
    logic [DIV_W-1:0]        pend_q [NUM_CH];
    logic [DIV_W-1:0]        pend_d [NUM_CH];
    logic [DIV_W-1:0]        cnt_q  [NUM_CH];
    logic [DIV_W-1:0]        cnt_d  [NUM_CH];
    logic                    enter_run;
    logic                    budget_end;

    // Next-state and next-output logic; ch_en is computed from the next counter so the
    // registered pulse lines up with the cycle in which the counter reads D-1.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        running_d   = running_q;
        done_d      = done_q;
        ch_en_d     = '0;
        ch_clk_d    = ch_clk_q;
        for (int k = 0; k < NUM_CH; k++) begin
            act_d[k]  = act_q[k];
            pend_d[k] = pend_q[k];
            cnt_d[k]  = cnt_q[k];
        end

        enter_run  = start && !stop && (state_q != ST_RUN);
        budget_end = BOUNDED && (cycle_cnt_q == LAST_CYCLE);

        if (cfg_load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                pend_d[k] = div_cfg[k*DIV_W +: DIV_W];
            end
        end

        if (stop) begin
            state_d   = ST_IDLE;
            running_d = 1'b0;
            done_d    = 1'b0;
            ch_clk_d  = '0;
        end else if (enter_run) begin
            state_d     = ST_RUN;
            cycle_cnt_d = '0;
            running_d   = 1'b1;
            done_d      = 1'b0;
            ch_clk_d    = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                act_d[k]   = div_cfg[k*DIV_W +: DIV_W];
                pend_d[k]  = div_cfg[k*DIV_W +: DIV_W];
                cnt_d[k]   = '0;
                ch_en_d[k] = (div_cfg[k*DIV_W +: DIV_W] == DIV_W'(1));
            end
        end else if (state_q == ST_RUN) begin
            ch_clk_d    = ch_clk_q ^ ch_en_q;
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (budget_end) begin
                state_d   = ST_DONE;
                running_d = 1'b0;
                done_d    = 1'b1;
            end
            // A disabled channel or one at its wrap point is the only place a new divide is adopted.
            for (int k = 0; k < NUM_CH; k++) begin
                if (act_q[k] == '0) begin
                    act_d[k] = pend_q[k];
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == act_q[k] - DIV_W'(1)) begin
                    act_d[k] = pend_q[k];
                    cnt_d[k] = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + DIV_W'(1);
                end
                ch_en_d[k] = !budget_end && (act_d[k] != '0) &&
                             (cnt_d[k] == act_d[k] - DIV_W'(1));
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            ch_en_q     <= '0;
            ch_clk_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                act_q[k]  <= '0;
                pend_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            running_q   <= running_d;
            done_q      <= done_d;
            ch_en_q     <= ch_en_d;
            ch_clk_q    <= ch_clk_d;
            for (int k = 0; k < NUM_CH; k++) begin
                act_q[k]  <= act_d[k];
                pend_q[k] <= pend_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign ch_en     = ch_en_q;
    assign ch_clk    = ch_clk_q;
    assign running   = running_q;
    assign done      = done_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: a bounded-run instance and a free-running 4-bit-counter instance
// share stimulus; a pulse-schedule reference model predicts every cycle's outputs.
module tb_clk_en_gen;

    localparam int unsigned NCH  = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned RC0  = 20;
    localparam int unsigned CW1  = 4;

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] sclk;
        logic           run;
        logic           dn;
        logic [31:0]    cnt;
    } obs_t;

    logic              clk25 = 1'b0;
    logic              reset_n;
    logic              start;
    logic              stop;
    logic              cfg_load;
    logic [NCH*DW-1:0] div_cfg;

    logic [NCH-1:0] ch_en0, ch_clk0, ch_en1, ch_clk1;
    logic           running0, done0, running1, done1;
    logic [31:0]    cycle_cnt0;
    logic [CW1-1:0] cycle_cnt1;

    int vectors    = 0;
    int miscompares = 0;

    obs_t q0[$];
    obs_t q1[$];

    always #5 clk25 = ~clk25;

    clk_en_gen #(.NUM_CH(NCH), .DIV_W(DW), .CNT_W(32), .RUN_CYCLES(RC0)) u_dut (
        .clk25(clk25), .reset_n(reset_n), .start(start), .stop(stop),
        .div_cfg(div_cfg), .cfg_load(cfg_load),
        .ch_en(ch_en0), .ch_clk(ch_clk0), .running(running0), .done(done0),
        .cycle_cnt(cycle_cnt0)
    );

    clk_en_gen #(.NUM_CH(NCH), .DIV_W(DW), .CNT_W(CW1), .RUN_CYCLES(0)) u_dut_free (
        .clk25(clk25), .reset_n(reset_n), .start(start), .stop(stop),
        .div_cfg(div_cfg), .cfg_load(cfg_load),
        .ch_en(ch_en1), .ch_clk(ch_clk1), .running(running1), .done(done1),
        .cycle_cnt(cycle_cnt1)
    );

    // Reference model: each channel is tracked as "time of next pulse" in run-relative cycles.
    int          m_st   [2];            // 0 idle, 1 run, 2 done
    longint      m_t    [2];
    longint      m_cyc  [2];
    int          m_d    [2][NCH];
    longint      m_nxt  [2][NCH];
    int          m_pend [2][NCH];
    bit [NCH-1:0] m_en  [2];
    bit [NCH-1:0] m_clk [2];
    bit          m_run  [2];
    bit          m_done [2];

    function automatic void model_step(input int m, input bit rst_v, input bit st_v,
                                       input bit sp_v, input bit ld_v, input logic [63:0] cfg);
        int           ncfg [NCH];
        int           pold [NCH];
        bit [NCH-1:0] en_old;
        longint       rc;
        longint       modulus;
        rc      = (m == 0) ? longint'(RC0) : 64'd0;
        modulus = (m == 0) ? (64'd1 << 32) : (64'd1 << CW1);
        for (int k = 0; k < NCH; k++) begin
            ncfg[k] = int'(cfg[k*DW +: DW]);
            pold[k] = m_pend[m][k];
        end
        en_old = m_en[m];
        m_en[m] = '0;
        if (!rst_v) begin
            m_st[m] = 0; m_t[m] = 0; m_cyc[m] = 0; m_clk[m] = '0;
            m_run[m] = 1'b0; m_done[m] = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                m_d[m][k] = 0; m_nxt[m][k] = 0; m_pend[m][k] = 0;
            end
            return;
        end
        if (sp_v) begin
            m_st[m] = 0; m_run[m] = 1'b0; m_done[m] = 1'b0; m_clk[m] = '0;
        end else if (st_v && m_st[m] != 1) begin
            m_st[m] = 1; m_t[m] = 0; m_cyc[m] = 0; m_clk[m] = '0;
            m_run[m] = 1'b1; m_done[m] = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                m_d[m][k]    = ncfg[k];
                m_pend[m][k] = ncfg[k];
                m_nxt[m][k]  = longint'(ncfg[k]) - 1;
                m_en[m][k]   = (ncfg[k] > 0) && (m_nxt[m][k] == 0);
            end
        end else if (m_st[m] == 1) begin
            m_clk[m] = m_clk[m] ^ en_old;
            for (int k = 0; k < NCH; k++) begin
                if (m_d[m][k] == 0 || en_old[k]) begin
                    m_d[m][k]   = pold[k];
                    m_nxt[m][k] = m_t[m] + longint'(pold[k]);
                end
            end
            m_t[m]   = m_t[m] + 1;
            m_cyc[m] = (m_cyc[m] + 1) % modulus;
            if (rc != 0 && m_t[m] == rc) begin
                m_st[m] = 2; m_run[m] = 1'b0; m_done[m] = 1'b1;
            end else begin
                for (int k = 0; k < NCH; k++)
                    m_en[m][k] = (m_d[m][k] > 0) && (m_t[m] == m_nxt[m][k]);
            end
        end
        if (ld_v) begin
            for (int k = 0; k < NCH; k++) m_pend[m][k] = ncfg[k];
        end
    endfunction

    function automatic obs_t model_obs(input int m);
        obs_t o;
        o.en = m_en[m]; o.sclk = m_clk[m]; o.run = m_run[m]; o.dn = m_done[m];
        o.cnt = 32'(m_cyc[m]);
        return o;
    endfunction

    function automatic obs_t dut_obs(input int m);
        obs_t o;
        if (m == 0) begin
            o.en = ch_en0; o.sclk = ch_clk0; o.run = running0; o.dn = done0; o.cnt = cycle_cnt0;
        end else begin
            o.en = ch_en1; o.sclk = ch_clk1; o.run = running1; o.dn = done1; o.cnt = 32'(cycle_cnt1);
        end
        return o;
    endfunction

    task automatic check_obs(input obs_t exp_o, input obs_t act, input string name);
        vectors++;
        if (act.en !== exp_o.en || act.sclk !== exp_o.sclk || act.run !== exp_o.run ||
            act.dn !== exp_o.dn || act.cnt !== exp_o.cnt) begin
            miscompares++;
            $display("FAIL %s t=%0t: got en=%b clk=%b run=%b done=%b cnt=%0d, want en=%b clk=%b run=%b done=%b cnt=%0d",
                     name, $time, act.en, act.sclk, act.run, act.dn, act.cnt,
                     exp_o.en, exp_o.sclk, exp_o.run, exp_o.dn, exp_o.cnt);
        end
    endtask

    // Monitor: after every active edge, pop the predicted response and compare.
    always @(posedge clk25) begin
        #1;
        if (q0.size() > 0) check_obs(q0.pop_front(), dut_obs(0), "bounded");
        if (q1.size() > 0) check_obs(q1.pop_front(), dut_obs(1), "freerun");
    end

    logic [63:0] cur_cfg;

    task automatic drive(input bit rst_v, input bit st_v, input bit sp_v, input bit ld_v,
                         input logic [63:0] cfg_v);
        bit falling;
        @(negedge clk25);
        falling  = (reset_n === 1'b1) && !rst_v;
        reset_n  = rst_v;
        start    = st_v;
        stop     = sp_v;
        cfg_load = ld_v;
        div_cfg  = cfg_v;
        model_step(0, rst_v, st_v, sp_v, ld_v, cfg_v);
        model_step(1, rst_v, st_v, sp_v, ld_v, cfg_v);
        if (falling) begin
            #1;
            check_obs(model_obs(0), dut_obs(0), "async_reset_bounded");
            check_obs(model_obs(1), dut_obs(1), "async_reset_freerun");
        end
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, cur_cfg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rs, st, sp, ld;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_load = 1'b0; div_cfg = '0;
        cur_cfg = '0;

        // Reset then idle.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, cur_cfg);
        idle(5);

        // Basic run to budget with ch3..ch0 = 0,1,3,5.
        cur_cfg = {16'd0, 16'd1, 16'd3, 16'd5};
        drive(1'b1, 1'b1, 1'b0, 1'b0, cur_cfg);
        idle(25);

        // Restart from DONE; mid-run retune ch0 to 2 at cycle_cnt 6.
        drive(1'b1, 1'b1, 1'b0, 1'b0, cur_cfg);
        idle(6);
        cur_cfg = {16'd0, 16'd1, 16'd3, 16'd2};
        drive(1'b1, 1'b0, 1'b0, 1'b1, cur_cfg);
        idle(15);

        // Enable a disabled channel mid-run, then start+stop together.
        cur_cfg = {16'd0, 16'd1, 16'd3, 16'd5};
        drive(1'b1, 1'b1, 1'b0, 1'b0, cur_cfg);
        idle(3);
        cur_cfg = {16'd2, 16'd1, 16'd3, 16'd5};
        drive(1'b1, 1'b0, 1'b0, 1'b1, cur_cfg);
        idle(4);
        drive(1'b1, 1'b1, 1'b1, 1'b0, cur_cfg);
        idle(3);

        // Reset during cycle 7 of a run, then restart.
        drive(1'b1, 1'b1, 1'b0, 1'b0, cur_cfg);
        idle(7);
        drive(1'b0, 1'b0, 1'b0, 1'b0, cur_cfg);
        drive(1'b0, 1'b0, 1'b0, 1'b0, cur_cfg);
        idle(2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, cur_cfg);
        idle(40);

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            rs = ($urandom_range(0, 999) >= 4);
            st = ($urandom_range(0, 99) < 4);
            sp = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 99) < 10);
            if (ld || st) begin
                for (int k = 0; k < NCH; k++)
                    cur_cfg[k*DW +: DW] = ($urandom_range(0, 9) == 0) ?
                        DW'($urandom_range(7, 40)) : DW'($urandom_range(0, 6));
            end
            drive(rs, st, sp, ld, cur_cfg);
        end
        idle(2);

        @(posedge clk25);
        #2;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending entries, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
